// File: rtl/pulp_pwr_domain_seq.sv
// Power-up/power-down sequencer for one switchable voltage domain behind a level-shifter ring.
// Optional ack-timeout fault detection is enabled with `define PULP_PWR_SEQ_TIMEOUT_EN.
module pulp_pwr_domain_seq #(
  parameter int unsigned IsoDelay      = 4,
  parameter int unsigned PwrSettle     = 16,
  parameter int unsigned CntWidth      = 8,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwr_req_i,
  input  logic pwr_sw_ack_i,
  output logic pwr_sw_en_o,
  output logic iso_en_o,
  output logic clk_en_o,
  output logic dom_rst_no,
  output logic domain_on_o,
  output logic busy_o,
  output logic err_o
);

  typedef enum logic [3:0] {
    ST_OFF     = 4'd0,
    ST_PWR_UP  = 4'd1,
    ST_SETTLE  = 4'd2,
    ST_RST_REL = 4'd3,
    ST_ISO_REL = 4'd4,
    ST_ON      = 4'd5,
    ST_ISO_SET = 4'd6,
    ST_CLK_OFF = 4'd7,
    ST_PWR_DN  = 4'd8,
    ST_FAULT   = 4'd9
  } state_e;

  localparam logic [CntWidth-1:0] SettleLast = CntWidth'(PwrSettle - 32'd1);
  localparam logic [CntWidth-1:0] IsoLast    = CntWidth'(IsoDelay - 32'd1);

  state_e              state_r;
  state_e              state_next_s;
  logic [CntWidth-1:0] cnt_r;
  logic                cnt_run_s;
  logic                ack_meta_r;
  logic                ack_sync_r;
  logic                ack_s;

  // Output vector {sw_en, iso, clk_en, rst_n, domain_on, busy}; unknown codes decode to clamped-off.
  function automatic logic [5:0] decode_outs(input state_e s);
    logic [5:0] v;
    case (s)
      ST_OFF:     v = 6'b010000;
      ST_PWR_UP:  v = 6'b110001;
      ST_SETTLE:  v = 6'b110001;
      ST_RST_REL: v = 6'b111101;
      ST_ISO_REL: v = 6'b101101;
      ST_ON:      v = 6'b101110;
      ST_ISO_SET: v = 6'b111101;
      ST_CLK_OFF: v = 6'b110001;
      ST_PWR_DN:  v = 6'b010001;
      ST_FAULT:   v = 6'b010000;
      default:    v = 6'b010000;
    endcase
    return v;
  endfunction

  assign ack_s = ack_sync_r;

  // Next-state and counter-enable decode.
  always_comb begin
    state_next_s = state_r;
    cnt_run_s    = 1'b0;
    case (state_r)
      ST_OFF: begin
        if (pwr_req_i) state_next_s = ST_PWR_UP;
        else           state_next_s = ST_OFF;
      end
      ST_PWR_UP: begin
        if (ack_s) begin
          state_next_s = ST_SETTLE;
        end else begin
`ifdef PULP_PWR_SEQ_TIMEOUT_EN
          cnt_run_s = 1'b1;
          if (cnt_r == CntWidth'(TimeoutCycles - 32'd1)) state_next_s = ST_FAULT;
          else                                           state_next_s = ST_PWR_UP;
`else
          state_next_s = ST_PWR_UP;
`endif
        end
      end
      ST_SETTLE: begin
        cnt_run_s = 1'b1;
        if (cnt_r == SettleLast) state_next_s = ST_RST_REL;
        else                     state_next_s = ST_SETTLE;
      end
      ST_RST_REL: begin
        cnt_run_s = 1'b1;
        if (cnt_r == IsoLast) state_next_s = ST_ISO_REL;
        else                  state_next_s = ST_RST_REL;
      end
      ST_ISO_REL: state_next_s = ST_ON;
      ST_ON: begin
        if (!pwr_req_i) state_next_s = ST_ISO_SET;
        else            state_next_s = ST_ON;
      end
      ST_ISO_SET: begin
        cnt_run_s = 1'b1;
        if (cnt_r == IsoLast) state_next_s = ST_CLK_OFF;
        else                  state_next_s = ST_ISO_SET;
      end
      ST_CLK_OFF: state_next_s = ST_PWR_DN;
      ST_PWR_DN: begin
        if (!ack_s) begin
          state_next_s = ST_OFF;
        end else begin
`ifdef PULP_PWR_SEQ_TIMEOUT_EN
          cnt_run_s = 1'b1;
          if (cnt_r == CntWidth'(TimeoutCycles - 32'd1)) state_next_s = ST_FAULT;
          else                                           state_next_s = ST_PWR_DN;
`else
          state_next_s = ST_PWR_DN;
`endif
        end
      end
      ST_FAULT: state_next_s = ST_FAULT;
      // A corrupted state drops the switch and waits for the chain to confirm it is off.
      default: state_next_s = ST_PWR_DN;
    endcase
  end

  // State, counter, ack synchroniser and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_OFF;
      cnt_r       <= {CntWidth{1'b0}};
      ack_meta_r  <= 1'b0;
      ack_sync_r  <= 1'b0;
      pwr_sw_en_o <= 1'b0;
      iso_en_o    <= 1'b1;
      clk_en_o    <= 1'b0;
      dom_rst_no  <= 1'b0;
      domain_on_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      ack_meta_r <= pwr_sw_ack_i;
      ack_sync_r <= ack_meta_r;
      state_r    <= state_next_s;
      if (state_next_s != state_r) cnt_r <= {CntWidth{1'b0}};
      else if (cnt_run_s)          cnt_r <= cnt_r + {{(CntWidth-1){1'b0}}, 1'b1};
      else                         cnt_r <= cnt_r;
      // Outputs are decoded from the next state so they change on the same edge as state_r.
      {pwr_sw_en_o, iso_en_o, clk_en_o, dom_rst_no, domain_on_o, busy_o} <= decode_outs(state_next_s);
    end
  end

`ifdef PULP_PWR_SEQ_TIMEOUT_EN
  logic err_r;

  // Sticky timeout error, cleared only by rst_ni.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (state_next_s == ST_FAULT);
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pulp_pwr_domain_seq.sv
// Directed self-checking bench for pulp_pwr_domain_seq (default parameters).
module tb_pulp_pwr_domain_seq;

  logic clk;
  logic rst_n;
  logic pwr_req;
  logic ack_follow;
  logic ack_force;
  logic pwr_sw_ack;
  logic pwr_sw_en, iso_en, clk_en, dom_rst_n, domain_on, busy, err;
  logic [6:0] obs;

  int checks   = 0;
  int failures = 0;
  int inv_viol = 0;

  // {sw_en, iso, clk_en, rst_n, domain_on, busy, err}
  localparam logic [6:0] V_OFF    = 7'b0100000;
  localparam logic [6:0] V_UP     = 7'b1100010;
  localparam logic [6:0] V_RREL   = 7'b1111010;
  localparam logic [6:0] V_IREL   = 7'b1011010;
  localparam logic [6:0] V_ON     = 7'b1011100;
  localparam logic [6:0] V_ISET   = 7'b1111010;
  localparam logic [6:0] V_CLKOFF = 7'b1100010;
  localparam logic [6:0] V_PDN    = 7'b0100010;
  localparam logic [6:0] V_FAULT  = 7'b0100001;

  assign pwr_sw_ack = ack_follow ? pwr_sw_en : ack_force;
  assign obs = {pwr_sw_en, iso_en, clk_en, dom_rst_n, domain_on, busy, err};

  pulp_pwr_domain_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pwr_req_i    (pwr_req),
    .pwr_sw_ack_i (pwr_sw_ack),
    .pwr_sw_en_o  (pwr_sw_en),
    .iso_en_o     (iso_en),
    .clk_en_o     (clk_en),
    .dom_rst_no   (dom_rst_n),
    .domain_on_o  (domain_on),
    .busy_o       (busy),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clamp must be active whenever the domain is in reset or unpowered.
  always @(negedge clk) begin
    if (!iso_en && (!dom_rst_n || !pwr_sw_en)) inv_viol++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    pwr_req    = 1'b0;
    ack_follow = 1'b1;
    ack_force  = 1'b0;
    #23;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Expected outputs k edges after pwr_req rises in OFF.
  function automatic logic [6:0] exp_up(input int k);
    if (k <= 19)      return V_UP;
    else if (k <= 23) return V_RREL;
    else if (k == 24) return V_IREL;
    else              return V_ON;
  endfunction

  // Expected outputs k edges after pwr_req falls in ON.
  function automatic logic [6:0] exp_dn(input int k);
    if (k <= 4)      return V_ISET;
    else if (k == 5) return V_CLKOFF;
    else if (k <= 8) return V_PDN;
    else             return V_OFF;
  endfunction

  initial begin
    do_reset();
    check_val("reset_vec", 32'(obs), 32'(V_OFF));

    // 1: idle in OFF
    for (int k = 0; k < 50; k++) begin
      tick();
      check_val("idle_off", 32'(obs), 32'(V_OFF));
    end

    // 2: full power-up with ack following sw_en
    pwr_req = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      tick();
      check_val($sformatf("up_k%0d", k), 32'(obs), 32'(exp_up(k)));
    end

    // 3: power-down from ON
    pwr_req = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check_val($sformatf("dn_k%0d", k), 32'(obs), 32'(exp_dn(k)));
    end

    // 4: 3-cycle request pulse -> full up then full down
    pwr_req = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (k == 3) pwr_req = 1'b0;
      if (k <= 25) check_val($sformatf("pulse_up_k%0d", k), 32'(obs), 32'(exp_up(k)));
      else         check_val($sformatf("pulse_dn_k%0d", k), 32'(obs), 32'(exp_dn(k - 25)));
    end

    // 5: ack never arrives
    ack_follow = 1'b0;
    ack_force  = 1'b0;
    pwr_req    = 1'b1;
`ifdef PULP_PWR_SEQ_TIMEOUT_EN
    for (int k = 1; k <= 255; k++) tick();
    check_val("tmo_pwr_up", 32'(obs), 32'(V_UP));
    tick();
    check_val("tmo_fault", 32'(obs), 32'(V_FAULT));
    pwr_req = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check_val("fault_sticky", 32'(obs), 32'(V_FAULT));
`else
    for (int k = 1; k <= 300; k++) tick();
    check_val("no_tmo_pwr_up", 32'(obs), 32'(V_UP));
`endif
    do_reset();
    check_val("reset_after_tmo", 32'(obs), 32'(V_OFF));

    // 6a: async reset during SETTLE
    pwr_req = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    check_val("pre_rst_settle", 32'(obs), 32'(V_UP));
    #2 rst_n = 1'b0;
    #1 check_val("async_rst_settle", 32'(obs), 32'(V_OFF));
    do_reset();
    tick();
    check_val("off_after_rst_settle", 32'(obs), 32'(V_OFF));

    // 6b: async reset during ISO_SET
    pwr_req = 1'b1;
    for (int k = 1; k <= 25; k++) tick();
    check_val("pre_rst_on", 32'(obs), 32'(V_ON));
    pwr_req = 1'b0;
    tick();
    tick();
    check_val("pre_rst_iso_set", 32'(obs), 32'(V_ISET));
    #2 rst_n = 1'b0;
    #1 check_val("async_rst_iso_set", 32'(obs), 32'(V_OFF));
    do_reset();
    tick();
    check_val("off_after_rst_iso", 32'(obs), 32'(V_OFF));

    check_val("iso_invariant", 32'(inv_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
